// File: rtl/usb_reset_sequencer.sv
// USB-domain reset sequencer: synchronises the PLL lock flag, releases rst_usb after a stable
// interval and holds it for a minimum time on lock loss or sw_reset. Option: USB_RST_LOSS_COUNT_EN.
module usb_reset_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4800,
   parameter int HOLD_CYCLES   = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       sw_reset,
   output logic       rst_usb,
   output logic       ready,
   output logic [1:0] state
`ifdef USB_RST_LOSS_COUNT_EN
   ,
   output logic [7:0] loss_count
`endif
);

   localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABILIZE = 2'd1,
      ST_RUN       = 2'd2,
      ST_HOLD      = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   locked_s;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rst_usb_q, rst_usb_d;
   logic                   ready_q, ready_d;

   assign locked_s = sync_q[SYNC_STAGES-1];

   // Synchroniser shift: bit 0 captures the asynchronous lock flag.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], locked};
   end

   // Next state, shared counter and registered reset/ready values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_STABILIZE;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d   = {CNT_W{1'b0}};
            end
         end
         ST_STABILIZE: begin
            // Any dropout discards all accumulated stable time.
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!locked_s || sw_reset) begin
               state_d = ST_HOLD;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d   = {CNT_W{1'b0}};
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
      rst_usb_d = (state_d != ST_RUN);
      ready_d   = (state_d == ST_RUN);
   end

   // State, counter, synchroniser and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= {SYNC_STAGES{1'b0}};
         state_q   <= ST_WAIT_LOCK;
         cnt_q     <= {CNT_W{1'b0}};
         rst_usb_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rst_usb_q <= rst_usb_d;
         ready_q   <= ready_d;
      end
   end

   assign rst_usb = rst_usb_q;
   assign ready   = ready_q;
   assign state   = state_q;

`ifdef USB_RST_LOSS_COUNT_EN
   logic [7:0] loss_count_q, loss_count_d;
   logic       loss_inc_s;

   // A RUN exit with lock low counts even if sw_reset was also present.
   always_comb begin
      loss_inc_s = (state_q == ST_RUN) && !locked_s;
      if (loss_inc_s && (loss_count_q != 8'hFF)) begin
         loss_count_d = loss_count_q + 8'd1;
      end else begin
         loss_count_d = loss_count_q;
      end
   end

   // Saturating loss counter, cleared only by reset_n.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         loss_count_q <= 8'd0;
      end else begin
         loss_count_q <= loss_count_d;
      end
   end

   assign loss_count = loss_count_q;
`endif

endmodule

// File: tb/tb_usb_reset_sequencer.sv
// Directed bench for usb_reset_sequencer with SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4.
module tb_usb_reset_sequencer;

   logic       clock;
   logic       reset_n;
   logic       locked;
   logic       sw_reset;
   logic       rst_usb;
   logic       ready;
   logic [1:0] state;
`ifdef USB_RST_LOSS_COUNT_EN
   logic [7:0] loss_count;
`endif

   int n_cmp;
   int n_bad;

   usb_reset_sequencer #(
      .SYNC_STAGES  (2),
      .STABLE_CYCLES(8),
      .HOLD_CYCLES  (4)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .locked    (locked),
      .sw_reset  (sw_reset),
      .rst_usb   (rst_usb),
      .ready     (ready),
      .state     (state)
`ifdef USB_RST_LOSS_COUNT_EN
      ,
      .loss_count(loss_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge.
   task automatic step;
      @(posedge clock);
      #1;
   endtask

   // Hold reset, then release so the following rising edge is E0.
   task automatic apply_reset(input logic lk);
      reset_n  = 1'b0;
      locked   = lk;
      sw_reset = 1'b0;
      repeat (3) step();
      reset_n  = 1'b1;
   endtask

   task automatic test_reset;
      reset_n  = 1'b0;
      locked   = 1'b0;
      sw_reset = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (rst_usb !== 1'b1) begin n_bad++; $display("FAIL reset_rst_usb got %b want 1", rst_usb); end
      n_cmp++;
      if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready); end
      n_cmp++;
      if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", state); end
`ifdef USB_RST_LOSS_COUNT_EN
      n_cmp++;
      if (loss_count !== 8'd0) begin n_bad++; $display("FAIL reset_loss got %0d want 0", loss_count); end
`endif
   endtask

   task automatic test_power_on;
      logic [1:0] exp_st;
      logic       exp_rst;
      apply_reset(1'b1);
      for (int e = 0; e <= 11; e++) begin
         step();
         exp_st  = (e < 2) ? 2'd0 : ((e <= 9) ? 2'd1 : 2'd2);
         exp_rst = (e < 10);
         n_cmp++;
         if (state !== exp_st) begin n_bad++; $display("FAIL pon_state E0+%0d got %0d want %0d", e, state, exp_st); end
         n_cmp++;
         if (rst_usb !== exp_rst) begin n_bad++; $display("FAIL pon_rst E0+%0d got %b want %b", e, rst_usb, exp_rst); end
         n_cmp++;
         if (ready !== !exp_rst) begin n_bad++; $display("FAIL pon_ready E0+%0d got %b want %b", e, ready, !exp_rst); end
      end
   endtask

   task automatic test_glitch;
      logic [1:0] exp_st;
      logic       exp_rst;
      apply_reset(1'b1);
      for (int e = 0; e <= 19; e++) begin
         step();
         if (e < 2) exp_st = 2'd0;
         else if (e <= 9) exp_st = 2'd1;
         else if (e == 10) exp_st = 2'd0;
         else if (e <= 18) exp_st = 2'd1;
         else exp_st = 2'd2;
         exp_rst = (e < 19);
         n_cmp++;
         if (state !== exp_st) begin n_bad++; $display("FAIL glitch_state E0+%0d got %0d want %0d", e, state, exp_st); end
         n_cmp++;
         if (rst_usb !== exp_rst) begin n_bad++; $display("FAIL glitch_rst E0+%0d got %b want %b", e, rst_usb, exp_rst); end
         // cnt is 5 after edge 7: drop lock for exactly one sample.
         if (e == 7) locked = 1'b0;
         if (e == 8) locked = 1'b1;
      end
   endtask

   task automatic test_lock_loss;
      logic [1:0] exp_st;
      logic       exp_rst;
      locked = 1'b0;
      for (int e = 0; e <= 16; e++) begin
         step();
         if (e == 0) locked = 1'b1;
         if (e < 2) exp_st = 2'd2;
         else if (e <= 5) exp_st = 2'd3;
         else if (e == 6) exp_st = 2'd0;
         else if (e <= 14) exp_st = 2'd1;
         else exp_st = 2'd2;
         exp_rst = !((e < 2) || (e >= 15));
         n_cmp++;
         if (state !== exp_st) begin n_bad++; $display("FAIL loss_state L+%0d got %0d want %0d", e, state, exp_st); end
         n_cmp++;
         if (rst_usb !== exp_rst) begin n_bad++; $display("FAIL loss_rst L+%0d got %b want %b", e, rst_usb, exp_rst); end
         n_cmp++;
         if (ready !== !exp_rst) begin n_bad++; $display("FAIL loss_ready L+%0d got %b want %b", e, ready, !exp_rst); end
      end
`ifdef USB_RST_LOSS_COUNT_EN
      n_cmp++;
      if (loss_count !== 8'd1) begin n_bad++; $display("FAIL loss_count_one got %0d want 1", loss_count); end
`endif
   endtask

   task automatic test_sw_reset;
      logic [1:0] exp_st;
      logic       exp_rst;
      sw_reset = 1'b1;
      for (int e = 0; e <= 14; e++) begin
         step();
         if (e == 0) sw_reset = 1'b0;
         if (e <= 3) exp_st = 2'd3;
         else if (e == 4) exp_st = 2'd0;
         else if (e <= 12) exp_st = 2'd1;
         else exp_st = 2'd2;
         exp_rst = (e < 13);
         n_cmp++;
         if (state !== exp_st) begin n_bad++; $display("FAIL sw_state S+%0d got %0d want %0d", e, state, exp_st); end
         n_cmp++;
         if (rst_usb !== exp_rst) begin n_bad++; $display("FAIL sw_rst S+%0d got %b want %b", e, rst_usb, exp_rst); end
         // A pulse during STABILIZE must be ignored.
         if (e == 7) sw_reset = 1'b1;
         if (e == 8) sw_reset = 1'b0;
      end
`ifdef USB_RST_LOSS_COUNT_EN
      n_cmp++;
      if (loss_count !== 8'd1) begin n_bad++; $display("FAIL sw_loss_unchanged got %0d want 1", loss_count); end
`endif
   endtask

   task automatic test_async_reset;
      apply_reset(1'b1);
      repeat (5) step();
      n_cmp++;
      if (state !== 2'd1) begin n_bad++; $display("FAIL async_pre_state got %0d want 1", state); end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (rst_usb !== 1'b1) begin n_bad++; $display("FAIL async_rst got %b want 1", rst_usb); end
      n_cmp++;
      if (ready !== 1'b0) begin n_bad++; $display("FAIL async_ready got %b want 0", ready); end
      n_cmp++;
      if (state !== 2'd0) begin n_bad++; $display("FAIL async_state got %0d want 0", state); end
`ifdef USB_RST_LOSS_COUNT_EN
      n_cmp++;
      if (loss_count !== 8'd0) begin n_bad++; $display("FAIL async_loss got %0d want 0", loss_count); end
`endif
      step();
      reset_n = 1'b1;
   endtask

`ifdef USB_RST_LOSS_COUNT_EN
   task automatic test_loss_count;
      apply_reset(1'b1);
      repeat (12) step();
      for (int i = 0; i < 300; i++) begin
         locked = 1'b0;
         step();
         locked = 1'b1;
         repeat (18) step();
         if (i == 254) begin
            n_cmp++;
            if (loss_count !== 8'd255) begin n_bad++; $display("FAIL loss_at_255 got %0d want 255", loss_count); end
         end
      end
      n_cmp++;
      if (loss_count !== 8'd255) begin n_bad++; $display("FAIL loss_saturate got %0d want 255", loss_count); end
      n_cmp++;
      if (state !== 2'd2) begin n_bad++; $display("FAIL loss_final_state got %0d want 2", state); end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (loss_count !== 8'd0) begin n_bad++; $display("FAIL loss_clear got %0d want 0", loss_count); end
      step();
      reset_n = 1'b1;
   endtask
`endif

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      reset_n  = 1'b0;
      locked   = 1'b0;
      sw_reset = 1'b0;
      test_reset();
      test_power_on();
      test_glitch();
      test_lock_loss();
      test_sw_reset();
      test_async_reset();
`ifdef USB_RST_LOSS_COUNT_EN
      test_loss_count();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
